// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver driven by a shared oversampling tick enable
module uart_rx #(
  parameter int OSR = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clk_rx,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);
  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] HALF_M1 = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OSR - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, data_n;
  logic valid_n, ferr_n;
  logic s1, rxd_s;
  // two-flop synchronizer for the asynchronous line, idling high
  always_ff @(posedge clk) begin
    s1 <= reset ? 1'b1 : i_rxd;
    rxd_s <= reset ? 1'b1 : s1;
  end
  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      o_data <= '0;
      o_valid <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      o_data <= data_n;
      o_valid <= valid_n;
      o_frame_err <= ferr_n;
      o_busy <= state_n != IDLE;
    end
  end
  // next state: start detect, mid-bit sampling and stop-bit validation
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    sh_n = sh;
    data_n = o_data;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = rxd_s ? IDLE : START;
      end
      START: if (i_clk_rx) begin
        cnt_n = cnt == HALF_M1 ? '0 : cnt + 1'b1;
        idx_n = cnt == HALF_M1 ? 3'd0 : idx;
        state_n = cnt != HALF_M1 ? START : rxd_s ? IDLE : DATA;
      end
      DATA: if (i_clk_rx) begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          sh_n = {rxd_s, sh[7:1]};
          idx_n = idx + 1'b1;
          state_n = idx == 3'd7 ? STOP : DATA;
        end else cnt_n = cnt + 1'b1;
      end
      STOP: if (i_clk_rx) begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          data_n = rxd_s ? sh : o_data;
          valid_n = rxd_s;
          ferr_n = !rxd_s;
          state_n = rxd_s ? IDLE : WAIT_HIGH;
        end else cnt_n = cnt + 1'b1;
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        state_n = rxd_s ? IDLE : WAIT_HIGH;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
